// File: rtl/dclk_tx_lanes.sv
// rtl/dclk_tx_lanes.sv - multi-lane flit serialiser with input FIFO and busy synchroniser
// Define DCLK_TX_PARITY_EN to append a per-lane even-parity beat to every frame.
module dclk_tx_lanes #(
   parameter int DATA_W      = 40,
   parameter int LANES       = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req,
   input  logic [DATA_W-1:0]             parallel_in,
   input  logic                          channel_busy,
   output logic                          tx_busy,
   output logic [LANES-1:0]              serial_out,
   output logic                          tx_active,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int BEATS = (DATA_W + LANES - 1) / LANES;
   localparam int SW    = BEATS * LANES;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int LW    = PW + 1;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_START  = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;
`ifdef DCLK_TX_PARITY_EN
   localparam logic [1:0] ST_PARITY = 2'd3;
`endif

   logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic                   tx_busy_q, tx_busy_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             state_q, state_d;
   logic [BW-1:0]          beat_q, beat_d;
   logic [SW-1:0]          shift_q, shift_d;
   logic [LANES-1:0]       out_q, out_d;
   logic                   active_q, active_d;
`ifdef DCLK_TX_PARITY_EN
   logic [LANES-1:0]       par_q, par_d;
`endif

   logic busy_sync;
   logic wr_en;
   logic pop;

   assign busy_sync = sync_q[SYNC_STAGES-1];
   assign wr_en     = req & ~tx_busy_q;
   // busy is only consulted when a new frame could start; frames in flight always finish
   assign pop       = (state_q == ST_IDLE) && (level_q != '0) && !busy_sync;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], channel_busy};
      mem_d    = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = parallel_in;
      end
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (wr_en && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!wr_en && pop) begin
         level_d = level_q - LW'(1);
      end
      tx_busy_d = (level_d == LW'(FIFO_DEPTH));
   end

   // Outputs are registered one cycle behind the state so serial_out never glitches.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      shift_d  = shift_q;
      out_d    = '0;
      active_d = (state_q != ST_IDLE);
`ifdef DCLK_TX_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               shift_d = SW'(mem_q[rd_ptr_q]);
               beat_d  = '0;
               state_d = ST_START;
`ifdef DCLK_TX_PARITY_EN
               par_d   = '0;
`endif
            end
         end
         ST_START: begin
            out_d   = '1;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            out_d   = shift_q[LANES-1:0];
            shift_d = shift_q >> LANES;
`ifdef DCLK_TX_PARITY_EN
            par_d   = par_q ^ shift_q[LANES-1:0];
`endif
            if (beat_q == BW'(BEATS - 1)) begin
               beat_d = '0;
`ifdef DCLK_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_IDLE;
`endif
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
`ifdef DCLK_TX_PARITY_EN
         ST_PARITY: begin
            out_d   = par_q;
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         tx_busy_q <= 1'b0;
         sync_q    <= '0;
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         shift_q   <= '0;
         out_q     <= '0;
         active_q  <= 1'b0;
`ifdef DCLK_TX_PARITY_EN
         par_q     <= '0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         tx_busy_q <= tx_busy_d;
         sync_q    <= sync_d;
         state_q   <= state_d;
         beat_q    <= beat_d;
         shift_q   <= shift_d;
         out_q     <= out_d;
         active_q  <= active_d;
`ifdef DCLK_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign tx_busy    = tx_busy_q;
   assign fifo_level = level_q;
   assign tx_active  = active_q;
   assign serial_out = out_q & {LANES{active_q}};

endmodule

// File: tb/tb_dclk_tx_lanes.sv
// tb/tb_dclk_tx_lanes.sv - self-checking bench for dclk_tx_lanes
module tb_dclk_tx_lanes;

   localparam int TW = 8;
   localparam int TL = 2;
   localparam int TD = 4;
   localparam int TS = 2;
   localparam int TBEATS = (TW + TL - 1) / TL;
`ifdef DCLK_TX_PARITY_EN
   localparam int TFRAME = TBEATS + 2;
`else
   localparam int TFRAME = TBEATS + 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req;
   logic [TW-1:0] din;
   logic          cbusy;
   logic          tx_busy;
   logic [TL-1:0] sout;
   logic          tx_act;
   logic [2:0]    lvl;

   logic          req_b;
   logic [4:0]    din_b;
   logic          cbusy_b;
   logic          tx_busy_b;
   logic [1:0]    sout_b;
   logic          tx_act_b;
   logic [2:0]    lvl_b;

   always #5 clk = ~clk;

   dclk_tx_lanes #(.DATA_W(TW), .LANES(TL), .FIFO_DEPTH(TD), .SYNC_STAGES(TS)) dut (
      .clk(clk), .reset(reset), .req(req), .parallel_in(din), .channel_busy(cbusy),
      .tx_busy(tx_busy), .serial_out(sout), .tx_active(tx_act), .fifo_level(lvl)
   );

   dclk_tx_lanes #(.DATA_W(5), .LANES(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .parallel_in(din_b), .channel_busy(cbusy_b),
      .tx_busy(tx_busy_b), .serial_out(sout_b), .tx_active(tx_act_b), .fifo_level(lvl_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a flit queue, a list of pending output beats, and a busy delay line.
   logic [TL:0]   pend[$];
   logic [TW-1:0] mfifo[$];
   logic          hist[$];
   int            ncyc = 0;
   int            next_pop = 0;
   logic          exp_act = 1'b0;
   logic [TL-1:0] exp_out = '0;
   logic          m_bsync, m_pop_ok, m_wr_ok;
   logic [TW-1:0] m_f;

   function automatic void push_frame(input logic [TW-1:0] f);
      logic [TL-1:0] par;
      logic [TL-1:0] beat;
      int idx;
      par = '0;
      pend.push_back({1'b1, {TL{1'b1}}});
      for (int b = 0; b < TBEATS; b++) begin
         for (int l = 0; l < TL; l++) begin
            idx = b * TL + l;
            beat[l] = (idx < TW) ? f[idx] : 1'b0;
            par[l]  = par[l] ^ beat[l];
         end
         pend.push_back({1'b1, beat});
      end
`ifdef DCLK_TX_PARITY_EN
      pend.push_back({1'b1, par});
`endif
   endfunction

   always @(posedge clk) begin
      ncyc++;
      if (!reset) begin
         pend.delete();
         mfifo.delete();
         hist.delete();
         next_pop = 0;
         exp_act  = 1'b0;
         exp_out  = '0;
      end else begin
         m_bsync  = (hist.size() == TS) ? hist[0] : 1'b0;
         m_pop_ok = (mfifo.size() > 0) && !m_bsync && (ncyc >= next_pop);
         m_wr_ok  = req && (mfifo.size() < TD);
         if (pend.size() > 0) {exp_act, exp_out} = pend.pop_front();
         else {exp_act, exp_out} = '0;
         if (m_pop_ok) begin
            m_f = mfifo.pop_front();
            push_frame(m_f);
            next_pop = ncyc + TFRAME + 1;
         end
         if (m_wr_ok) mfifo.push_back(din);
         hist.push_back(cbusy);
         if (hist.size() > TS) void'(hist.pop_front());
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         chk("m_tx_active", 32'(tx_act), 32'(exp_act));
         chk("m_serial_out", 32'(sout), 32'(exp_out));
         chk("m_fifo_level", 32'(lvl), 32'(mfifo.size()));
         chk("m_tx_busy", 32'(tx_busy), 32'(mfifo.size() == TD));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [TW-1:0] d);
      req = 1'b1;
      din = d;
      tick();
      req = 1'b0;
   endtask

   task automatic expect_beat(input string n, input logic a, input logic [1:0] v);
      tick();
      chk({n, "_act"}, 32'(tx_act), 32'(a));
      chk({n, "_out"}, 32'(sout), 32'(v));
   endtask

   task automatic expect_b(input string n, input logic a, input logic [1:0] v);
      tick();
      chk({n, "_act"}, 32'(tx_act_b), 32'(a));
      chk({n, "_out"}, 32'(sout_b), 32'(v));
   endtask

   int frames;
   logic prev_act;

   initial begin
      reset = 1'b0; req = 1'b0; din = '0; cbusy = 1'b0;
      req_b = 1'b0; din_b = '0; cbusy_b = 1'b0;
      repeat (3) tick();
      chk("rst_level", 32'(lvl), 32'd0);
      chk("rst_tx_busy", 32'(tx_busy), 32'd0);
      chk("rst_tx_active", 32'(tx_act), 32'd0);
      chk("rst_serial", 32'(sout), 32'd0);
      reset = 1'b1;
      repeat (4) tick();

      // 0xA5: start, 01, 01, 10, 10
      wr_a(8'hA5);
      chk("a5_k_act", 32'(tx_act), 32'd0);
      tick();
      chk("a5_k1_act", 32'(tx_act), 32'd0);
      expect_beat("a5_start", 1'b1, 2'b11);
      expect_beat("a5_b0", 1'b1, 2'b01);
      expect_beat("a5_b1", 1'b1, 2'b01);
      expect_beat("a5_b2", 1'b1, 2'b10);
      expect_beat("a5_b3", 1'b1, 2'b10);
`ifdef DCLK_TX_PARITY_EN
      expect_beat("a5_par", 1'b1, 2'b00);
`endif
      expect_beat("a5_end", 1'b0, 2'b00);

      // 0x01: start, 01, 00, 00, 00 (+ parity 01)
      wr_a(8'h01);
      tick();
      expect_beat("x01_start", 1'b1, 2'b11);
      expect_beat("x01_b0", 1'b1, 2'b01);
      expect_beat("x01_b1", 1'b1, 2'b00);
      expect_beat("x01_b2", 1'b1, 2'b00);
      expect_beat("x01_b3", 1'b1, 2'b00);
`ifdef DCLK_TX_PARITY_EN
      expect_beat("x01_par", 1'b1, 2'b01);
`endif
      expect_beat("x01_end", 1'b0, 2'b00);

      // DATA_W=5 padding: 0x1F -> start, 11, 11, 01
      req_b = 1'b1; din_b = 5'h1F;
      tick();
      req_b = 1'b0;
      tick();
      expect_b("pad_start", 1'b1, 2'b11);
      expect_b("pad_b0", 1'b1, 2'b11);
      expect_b("pad_b1", 1'b1, 2'b11);
      expect_b("pad_b2", 1'b1, 2'b01);
`ifdef DCLK_TX_PARITY_EN
      expect_b("pad_par", 1'b1, 2'b01);
`endif
      expect_b("pad_end", 1'b0, 2'b00);
      chk("pad_level", 32'(lvl_b), 32'd0);
      chk("pad_tx_busy", 32'(tx_busy_b), 32'd0);

      // fill while blocked, fifth write ignored, then drain four frames
      cbusy = 1'b1;
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         req = 1'b1;
         din = 8'(8'h11 * (i + 1));
         tick();
         if (i == 3) begin
            chk("full_level", 32'(lvl), 32'd4);
            chk("full_tx_busy", 32'(tx_busy), 32'd1);
         end
         if (i == 4) chk("ignored_level", 32'(lvl), 32'd4);
      end
      req = 1'b0;
      repeat (3) tick();
      chk("blocked_act", 32'(tx_act), 32'd0);
      cbusy = 1'b0;
      frames = 0;
      prev_act = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (tx_act && !prev_act) frames++;
         prev_act = tx_act;
      end
      chk("drain_frames", 32'(frames), 32'd4);
      chk("drain_level", 32'(lvl), 32'd0);

      // busy raised mid-frame: frame completes, next one waits
      wr_a(8'h3C);
      wr_a(8'hC3);
      tick();
      tick();
      cbusy = 1'b1;
      repeat (15) tick();
      chk("hold_level", 32'(lvl), 32'd1);
      chk("hold_act", 32'(tx_act), 32'd0);
      cbusy = 1'b0;
      repeat (15) tick();
      chk("release_level", 32'(lvl), 32'd0);

      // reset mid-frame with two flits queued
      wr_a(8'h5A);
      wr_a(8'h96);
      wr_a(8'h0F);
      repeat (3) tick();
      chk("pre_rst_level", 32'(lvl), 32'd2);
      chk("pre_rst_act", 32'(tx_act), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_act", 32'(tx_act), 32'd0);
      chk("abort_serial", 32'(sout), 32'd0);
      chk("abort_level", 32'(lvl), 32'd0);
      chk("abort_tx_busy", 32'(tx_busy), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      frames = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (tx_act) frames++;
      end
      chk("post_rst_active_cycles", 32'(frames), 32'd0);
      chk("post_rst_level", 32'(lvl), 32'd0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

endmodule

// File: doc/dclk_tx_lanes.md
Name: dclk_tx_lanes

Overview:
- Parametrised multi-lane serialiser for router output ports; successor to the single-lane flit transmitter.
- Buffers flits in a small input FIFO and frames each one as a start beat followed by data beats across LANES parallel serial wires.
- Starts a frame only when the downstream channel is not busy; channel_busy is synchronised internally.
- Sits between the router crossbar output and the inter-router serial link.

Parameters:
DATA_W, 40, flit width in bits (payload+address).
LANES, 2, number of serial wires; 1 reproduces the legacy single-wire link.
FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
SYNC_STAGES, 2, flops in the channel_busy synchroniser; >=2.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-low reset.
req  input  1  write strobe; flit accepted at posedge when req=1 and tx_busy=0.
parallel_in  input  DATA_W  flit to send.
channel_busy  input  1  asynchronous busy from the receiver.
tx_busy  output  1  FIFO full; upstream must not write.
serial_out  output  LANES  serial data, lane l = bit l.
tx_active  output  1  high during start, data and parity beats.
fifo_level  output  clog2(FIFO_DEPTH)+1  number of queued flits.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, fifo_level=0, tx_busy=0.
  - State IDLE, tx_active=0, serial_out=0, synchroniser cleared.
  - A frame in flight is aborted immediately; its flit is discarded.
- BEATS = ceil(DATA_W/LANES).
  - Beat b, lane l carries parallel_in[b*LANES+l].
  - Bit indices >= DATA_W are sent as 0.
- serial_out is gated by registered tx_active, so it is all-zero whenever tx_active=0.
- FIFO:
  - Write when req & !tx_busy; a write when full is ignored.
  - Pop occurs on the IDLE->START edge.
  - Simultaneous write and pop is legal whenever not full; fifo_level is unchanged.
  - tx_busy = (fifo_level == FIFO_DEPTH), registered.
- busy_sync is channel_busy after SYNC_STAGES flops.
- FSM:
  - IDLE: tx_active=0. If FIFO non-empty and busy_sync=0, load the head into the shift register, pop, and go to START.
  - START: 1 cycle; all lanes = 1; tx_active=1; go to DATA.
  - DATA: BEATS cycles; beat counter 0..BEATS-1; shift by LANES per cycle; after the last beat go to PARITY if enabled, else IDLE.
  - PARITY: see Optional Feature.
- busy_sync rising mid-frame does not abort or stall the frame. It is only checked in IDLE.
- Latency:
  - Flit written at edge k into an empty FIFO, with IDLE and busy_sync=0 → tx_active rises at edge k+2.
  - Frame length = 1+BEATS (+1 with parity) cycles.
  - Back-to-back frames have exactly one cycle with tx_active=0 between them.
- FIFO pointers wrap modulo FIFO_DEPTH.
- fifo_level saturates logically at FIFO_DEPTH because writes are blocked when full.

Optional Feature:
- Macro: DCLK_TX_PARITY_EN.
- Defined:
  - A PARITY state of 1 cycle follows DATA.
  - Lane l drives the even parity (XOR) of all BEATS bits it carried in that frame, padding included.
  - tx_active=1 during PARITY.
  - Frame length = BEATS+2.
- Undefined: no PARITY state; DATA goes directly to IDLE.

Test Plan:
- DATA_W=8, LANES=2; reset released, channel_busy=0; write 0xA5 at edge k → tx_active rises at edge k+2. serial_out as {lane1,lane0}: 11, 01, 01, 10, 10, then 00 with tx_active=0.
- Same config, DCLK_TX_PARITY_EN defined, write 0x01 → beats 11, 01, 00, 00, 00, then parity 01.
- DATA_W=5, LANES=2; write 0x1F → beats 11, 11, 11, 01 (bit 5 padded 0).
- FIFO_DEPTH=4, channel_busy=1, five consecutive writes → fifo_level=4 and tx_busy=1 after the 4th; the 5th is ignored. Release channel_busy → four frames sent with one idle cycle between each; fifo_level returns to 0.
- Raise channel_busy during DATA beat 1 → frame completes unchanged; no new frame starts until busy_sync=0.
- Assert reset during DATA beat 2 with 2 flits queued → tx_active=0 and serial_out=0 immediately, fifo_level=0; after release no frame is sent.
